tx_uart: RTL and testbench
==========================

TX_UART -- requirements
Module: tx_uart

Interface
REQ-001 Parameter NB_DATA, default 8: data bits per frame.
REQ-002 Parameter SB_TICK, default 16: i_tick pulses per stop period; legal values 16 (1 stop bit), 24 (1.5 stop bits) and 32 (2 stop bits).
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 i_clock, input, 1: the single clock; all state updates occur on its rising edge.
REQ-005 i_reset, input, 1: synchronous, active-low reset; sampled only on the rising edge of i_clock.
REQ-006 i_tick, input, 1: baud-rate-generator enable at 16x the bit rate; one-cycle pulse.
REQ-007 i_tx_start, input, 1: request to transmit i_data.
REQ-008 i_data, input, NB_DATA: byte to send; sampled on acceptance only.
REQ-009 o_tx, output, 1: serial line; idle level high; registered.
REQ-010 o_tx_done_tick, output, 1: one-cycle pulse marking the end of the stop period.
REQ-011 o_busy, output, 1: high whenever the state is not IDLE.

Function
REQ-012 The block SHALL implement the states IDLE, START, DATA, PARITY and STOP; the PARITY state SHALL be unreachable when PARITY = 0.
REQ-013 A tick counter SHALL be wide enough to hold SB_TICK-1; a data counter SHALL be ceil(log2(NB_DATA)) bits wide; the shift register SHALL be NB_DATA bits wide.
REQ-014 In IDLE with i_tx_start = 1, the block SHALL latch i_data into the shift register, clear both counters, compute the parity bit, enter START, and drive o_tx = 0, all at the same clock edge.
REQ-015 The tick counter SHALL advance only in cycles where i_tick = 1; cycles without i_tick SHALL hold all state.
REQ-016 START: on i_tick with the tick counter at 15, the block SHALL enter DATA, clear the tick counter, and drive o_tx = shift register[0].
REQ-017 DATA: on i_tick with the tick counter at 15, the block SHALL shift the register right by one and clear the tick counter.
REQ-018 DATA, continued: if the data counter equals NB_DATA-1, the block SHALL enter PARITY when PARITY ≠ 0, otherwise STOP; else it SHALL increment the data counter.
REQ-019 Bits SHALL be sent LSB first.
REQ-020 o_tx SHALL present each new bit at the same edge that the state or shift changes.
REQ-021 PARITY: o_tx SHALL equal the parity bit, where even = XOR of the data and odd = its inverse; after 16 ticks the block SHALL enter STOP.
REQ-022 STOP: o_tx SHALL be 1; on i_tick with the tick counter at SB_TICK-1, the block SHALL return to IDLE and assert o_tx_done_tick for exactly that one cycle.
REQ-023 i_tx_start SHALL be ignored whenever the state is not IDLE, including the cycle in which o_tx_done_tick is high.
REQ-024 A start asserted in the first cycle after done SHALL be accepted, giving back-to-back frames with no idle gap beyond that cycle.
REQ-025 Changes on i_data after acceptance SHALL NOT affect the frame in flight.
REQ-026 Frame length SHALL be exactly 16*(1+NB_DATA+(PARITY≠0)) + SB_TICK i_tick pulses.
REQ-027 An undefined state encoding SHALL recover to IDLE on the next edge, with o_tx = 1.

Reset
REQ-028 While i_reset = 0 at a rising edge, the block SHALL set state = IDLE, o_tx = 1, o_tx_done_tick = 0, o_busy = 0, and all counters and the shift register to 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, leaving o_tx = 1 on the next cycle, with no done pulse.
REQ-030 Reset SHALL take priority over i_tx_start and i_tick in the same cycle.

Verification
REQ-031 Basic frame: i_tick every cycle, PARITY = 0, SB_TICK = 16, send 0xA5. Required: o_tx is low for 16 cycles, then 1,0,1,0,0,1,0,1 for 16 cycles each, then high for 16 cycles; o_tx_done_tick pulses once, 160 cycles after acceptance.
REQ-032 Slow tick: i_tick every 4th cycle, send 0x3C. Required: each bit lasts 64 clocks, and the frame decodes as 0x3C.
REQ-033 Parity: PARITY = 1, send 0x07. Required: the parity bit is 1, and done arrives at 176 ticks. PARITY = 2, send 0x07. Required: the parity bit is 0.
REQ-034 Busy protection: assert i_tx_start with 0xFF during bit 3 of a 0x00 frame. Required: the serial data stays 0x00, and no second frame follows.
REQ-035 Back-to-back: hold i_tx_start high continuously with 0x55, then 0xAA. Required: two contiguous frames with one idle clock between them, and two done pulses.
REQ-036 Reset mid-frame: assert i_reset = 0 during DATA. Required: on the next cycle o_tx = 1 and o_busy = 0, and no done pulse appears; a subsequent start sends a full frame.

Source files
------------

// File: rtl/tx_uart.sv
// rtl/tx_uart.sv - UART transmitter with optional parity and configurable stop length
//
// Ports:
//   i_clock        : clock, all state updates on its rising edge
//   i_reset        : synchronous active-low reset
//   i_tick         : 16x bit-rate enable pulse, one cycle wide
//   i_tx_start     : request to send i_data, honoured only in IDLE
//   i_data         : NB_DATA-bit word, latched at acceptance
//   o_tx           : serial line, idle high, registered
//   o_tx_done_tick : one-cycle pulse at the end of the stop period
//   o_busy         : high whenever a frame is in progress
module tx_uart #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done_tick,
  output logic               o_busy
);

  localparam int NB_TICK = $clog2(SB_TICK);
  localparam int NB_DCNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_TICK-1:0] TICK_BIT  = NB_TICK'(15);
  localparam logic [NB_TICK-1:0] TICK_STOP = NB_TICK'(SB_TICK - 1);
  localparam logic [NB_DCNT-1:0] DCNT_LAST = NB_DCNT'(NB_DATA - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             r_state;
  logic [NB_TICK-1:0] r_tick_cnt;
  logic [NB_DCNT-1:0] r_data_cnt;
  logic [NB_DATA-1:0] r_shift;
  logic               r_parity;
  logic               r_tx;
  logic               r_done;

  logic [NB_DATA-1:0] w_shift_next;
  logic               w_parity;

  assign w_shift_next = r_shift >> 1;
  // Even parity is the XOR of the data bits; odd parity is its inverse.
  assign w_parity     = (PARITY == 2) ? ~(^i_data) : (^i_data);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_data_cnt <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (i_tx_start) begin
            r_state    <= S_START;
            r_shift    <= i_data;
            r_parity   <= w_parity;
            r_tick_cnt <= '0;
            r_data_cnt <= '0;
            r_tx       <= 1'b0;
          end
        end
        S_START: begin
          if (i_tick) begin
            if (r_tick_cnt == TICK_BIT) begin
              r_state    <= S_DATA;
              r_tick_cnt <= '0;
              r_tx       <= r_shift[0];
            end else begin
              r_tick_cnt <= r_tick_cnt + NB_TICK'(1);
            end
          end
        end
        S_DATA: begin
          if (i_tick) begin
            if (r_tick_cnt == TICK_BIT) begin
              r_shift    <= w_shift_next;
              r_tick_cnt <= '0;
              if (r_data_cnt == DCNT_LAST) begin
                if (PARITY != 0) begin
                  r_state <= S_PARITY;
                  r_tx    <= r_parity;
                end else begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_data_cnt <= r_data_cnt + NB_DCNT'(1);
                // Next bit is presented on the same edge as the shift.
                r_tx       <= w_shift_next[0];
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + NB_TICK'(1);
            end
          end
        end
        S_PARITY: begin
          if (i_tick) begin
            if (r_tick_cnt == TICK_BIT) begin
              r_state    <= S_STOP;
              r_tick_cnt <= '0;
              r_tx       <= 1'b1;
            end else begin
              r_tick_cnt <= r_tick_cnt + NB_TICK'(1);
            end
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (i_tick) begin
            if (r_tick_cnt == TICK_STOP) begin
              r_state    <= S_IDLE;
              r_tick_cnt <= '0;
              r_done     <= 1'b1;
            end else begin
              r_tick_cnt <= r_tick_cnt + NB_TICK'(1);
            end
          end
        end
        default: begin
          // Unused encodings fall straight back to an idle line.
          r_state    <= S_IDLE;
          r_tick_cnt <= '0;
          r_data_cnt <= '0;
          r_tx       <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx           = r_tx;
  assign o_tx_done_tick = r_done;
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_tx_uart.sv
// tb/tb_tx_uart.sv - scoreboard bench for tx_uart with no, even and odd parity instances
module tb_tx_uart;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic          start;
  logic [NB-1:0] data;

  logic w_tx   [3];
  logic w_done [3];
  logic w_busy [3];

  logic [NB-1:0] exp_q [3][$];
  int exp_done [3];
  int done_cnt [3];
  int n_vec = 0;
  int n_err = 0;
  int tick_div = 1;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    tx_uart #(.NB_DATA(NB), .SB_TICK(16), .PARITY(k)) u_dut (
      .i_clock        (clk),
      .i_reset        (rst_n),
      .i_tick         (tick),
      .i_tx_start     (start),
      .i_data         (data),
      .o_tx           (w_tx[k]),
      .o_tx_done_tick (w_done[k]),
      .o_busy         (w_busy[k])
    );
  end

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  task automatic tick_gen();
    int tcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      tick = ((tcnt % tick_div) == 0);
    end
  endtask

  // Decodes frames in tick time, sampling each bit at its 8th tick.
  task automatic monitor(input int k);
    int ph = 0;
    int cons = 0;
    int b;
    int sb;
    int ft;
    logic [NB-1:0] exp_d;
    logic [NB-1:0] got;
    logic          exp_p;
    sb = NB + 1 + ((k != 0) ? 1 : 0);
    ft = 16 * sb + 16;
    exp_d = '0;
    got = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        ph = 0;
        continue;
      end
      if (ph == 0) begin
        if (w_done[k] === 1'b1) begin
          done_cnt[k]++;
          chk($sformatf("tx%0d stray done", k), 1, 0);
        end
        if (w_tx[k] === 1'b0) begin
          ph = 1;
          cons = 0;
          got = '0;
          if (exp_q[k].size() == 0) begin
            chk($sformatf("tx%0d unexpected frame", k), 1, 0);
            exp_d = '0;
          end else begin
            exp_d = exp_q[k].pop_front();
          end
        end
      end else if (ph == 1) begin
        if (w_done[k] === 1'b1) chk($sformatf("tx%0d early done", k), 1, 0);
        if (tick === 1'b1 && (cons % 16) == 8) begin
          b = cons / 16;
          if (b == 0) begin
            chk($sformatf("tx%0d start bit", k), w_tx[k], 0);
          end else if (b <= NB) begin
            got[b-1] = w_tx[k];
          end else if (b < sb) begin
            exp_p = (k == 1) ? (^exp_d) : ~(^exp_d);
            chk($sformatf("tx%0d parity bit", k), w_tx[k], exp_p);
          end else begin
            chk($sformatf("tx%0d stop bit", k), w_tx[k], 1);
            chk($sformatf("tx%0d frame data", k), got, exp_d);
            ph = 2;
          end
        end
      end else begin
        if (w_done[k] === 1'b1) begin
          done_cnt[k]++;
          chk($sformatf("tx%0d done tick count", k), cons, ft);
          ph = 0;
        end else if (cons > ft + 2) begin
          chk($sformatf("tx%0d done timeout", k), 0, 1);
          ph = 0;
        end
      end
      if (tick === 1'b1) cons++;
    end
  endtask

  task automatic send(input logic [NB-1:0] d);
    @(posedge clk);
    #1;
    data = d;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q[k].push_back(d);
      exp_done[k]++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    data = ~d;
  endtask

  task automatic wait_done();
    int cyc = 0;
    while ((done_cnt[0] < exp_done[0] || done_cnt[1] < exp_done[1] ||
            done_cnt[2] < exp_done[2]) && cyc < 6000) begin
      @(posedge clk);
      cyc++;
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("tx%0d done count", k), done_cnt[k], exp_done[k]);
  endtask

  initial begin
    int cyc;
    int run;
    rst_n = 1'b0;
    tick  = 1'b0;
    start = 1'b0;
    data  = '0;
    for (int k = 0; k < 3; k++) begin
      exp_done[k] = 0;
      done_cnt[k] = 0;
    end
    fork
      tick_gen();
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    // Reset state, with start requested during reset
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tx%0d reset o_tx", k), w_tx[k], 1);
      chk($sformatf("tx%0d reset done", k), w_done[k], 0);
      chk($sformatf("tx%0d reset busy", k), w_busy[k], 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic frame 0xA5, done 160 cycles after acceptance
    send(8'hA5);
    cyc = -1;
    do begin
      @(negedge clk);
      cyc++;
    end while (w_done[0] !== 1'b1 && cyc < 1000);
    chk("tx0 done latency", cyc, 160);
    wait_done();

    // Parity frame 0x07
    send(8'h07);
    wait_done();

    // Slow tick: the run of four ones in 0x3C lasts 4*64 clocks
    tick_div = 4;
    send(8'h3C);
    cyc = 0;
    while (w_tx[0] !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    run = 0;
    while (w_tx[0] === 1'b1 && run < 2000) begin
      run++;
      @(negedge clk);
    end
    chk("tx0 slow high run", run, 256);
    wait_done();
    tick_div = 1;

    // Busy protection: start with 0xFF during bit 3 of a 0x00 frame
    send(8'h00);
    repeat (72) @(posedge clk);
    #1;
    start = 1'b1;
    data = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    repeat (200) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tx%0d busy after ignore", k), w_busy[k], 0);
      chk($sformatf("tx%0d no second frame", k), done_cnt[k], exp_done[k]);
    end

    // Back-to-back with start held high: 0x55 then 0xAA
    @(posedge clk);
    #1;
    data = 8'h55;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q[k].push_back(8'h55);
      exp_done[k]++;
    end
    @(posedge clk);
    #1;
    data = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      exp_q[k].push_back(8'hAA);
      exp_done[k]++;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (w_done[0] !== 1'b1 && cyc < 1000);
    chk("tx0 b2b line during done", w_tx[0], 1);
    @(negedge clk);
    chk("tx0 b2b restart start bit", w_tx[0], 0);
    chk("tx0 b2b restart busy", w_busy[0], 1);
    cyc = 0;
    while (w_done[2] !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Reset during DATA aborts the frame without a done pulse
    send(8'h5A);
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      exp_done[k]--;
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tx%0d abort o_tx", k), w_tx[k], 1);
      chk($sformatf("tx%0d abort busy", k), w_busy[k], 0);
    end
    repeat (300) @(posedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("tx%0d no done after abort", k), done_cnt[k], exp_done[k]);
    send(8'hC3);
    wait_done();

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
